ssg_capture: RTL and testbench

- Receive-side counterpart of the seven-segment font encoder.
- Monitors a multiplexed seven-segment bus (8 segment lines plus one-hot digit select) driven by an external or on-chip display scanner.
- Waits for each digit slot to be stable, then decodes the segment pattern back to a BCD value and decimal point, and keeps a per-digit register file.
- Used for display loopback self-test and for reading panels that expose only their segment lines.

---
 rtl/ssg_capture.sv | 108 ++++++++++
 tb/tb_ssg_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssg_capture.sv
// ssg_capture: watches a multiplexed seven-segment bus and decodes each stable digit slot
// back to BCD, a decimal point and a validity flag, held in a per-digit register file.
module ssg_capture #(
    parameter int NDIG   = 4,
    parameter int STABLE = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [7:0]                             ssg_in,
    input  logic [NDIG-1:0]                        sel_in,
    output logic [4*NDIG-1:0]                      digits,
    output logic [NDIG-1:0]                        dots,
    output logic [NDIG-1:0]                        bad,
    output logic                                   upd,
    output logic [(NDIG > 1 ? $clog2(NDIG) : 1)-1:0] upd_idx,
    output logic                                   frame_done
);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int CW = STABLE > 1 ? $clog2(STABLE) : 1;
    localparam int W  = 8 + NDIG;

    typedef enum logic {WAIT, HOLD} state_t;

    state_t          state;
    logic [W-1:0]    s1, s2, last;
    logic [CW-1:0]   cnt;
    logic [NDIG-1:0] mask;
    logic [NDIG-1:0] last_sel;
    logic [6:0]      last_seg;
    logic [IW-1:0]   sel_idx;
    logic [3:0]      dec_val;
    logic            sel_ok;

    // Vector layout is {ssg, sel}, so the segment byte sits above the select bits.
    assign last_sel = last[NDIG-1:0];
    assign last_seg = last[W-1:NDIG+1];
    assign sel_ok   = $onehot(last_sel);

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NDIG; k++)
            if (last_sel[k]) sel_idx = IW'(k);
    end

    always_comb begin
        dec_val = 4'hF;
        case (last_seg)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b0011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1110011: dec_val = 4'd9;
            default:    dec_val = 4'hF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            last       <= '0;
            cnt        <= '0;
            state      <= HOLD;
            mask       <= '0;
            digits     <= '1;
            dots       <= '0;
            bad        <= '1;
            upd        <= 1'b0;
            upd_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            s1         <= {ssg_in, sel_in};
            s2         <= s1;
            upd        <= 1'b0;
            frame_done <= 1'b0;
            if (s2 != last) begin
                last  <= s2;
                cnt   <= '0;
                state <= WAIT;
            end else if (state == WAIT) begin
                if (cnt != CW'(STABLE - 1)) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    state <= HOLD;
                    if (sel_ok) begin
                        digits[{sel_idx, 2'b00} +: 4] <= dec_val;
                        dots[sel_idx]                 <= last[NDIG];
                        bad[sel_idx]                  <= dec_val == 4'hF;
                        upd                           <= 1'b1;
                        upd_idx                       <= sel_idx;
                        // last_sel is one-hot here, so OR-ing it in marks exactly this digit.
                        if (&(mask | last_sel)) begin
                            frame_done <= 1'b1;
                            mask       <= '0;
                        end else begin
                            mask <= mask | last_sel;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ssg_capture.sv
// tb_ssg_capture: drives timed segment/select windows and compares the capture
// register file against a window-level reference model.
module tb_ssg_capture;
    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ssg_in;
    logic [3:0]  sel_in;
    logic [15:0] digits;
    logic [3:0]  dots, bad;
    logic        upd, frame_done;
    logic [1:0]  upd_idx;

    ssg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .ssg_in(ssg_in), .sel_in(sel_in),
        .digits(digits), .dots(dots), .bad(bad), .upd(upd),
        .upd_idx(upd_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int upd_seen = 0;
    int fd_seen = 0;

    logic [6:0] font [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

    logic [3:0] m_dig  [NDIG];
    logic       m_dot  [NDIG];
    logic       m_bad  [NDIG];
    logic       m_mask [NDIG];
    logic [7:0] p_ssg;
    logic [3:0] p_sel;

    function automatic void m_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_dig[i] = 4'hF; m_dot[i] = 1'b0; m_bad[i] = 1'b1; m_mask[i] = 1'b0;
        end
        p_ssg = '0;
        p_sel = '0;
    endfunction

    function automatic logic [15:0] m_digits();
        logic [15:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    function automatic logic [3:0] m_vec(input int which);
        logic [3:0] r;
        for (int i = 0; i < NDIG; i++) r[i] = which == 0 ? m_dot[i] : m_bad[i];
        return r;
    endfunction

    // Present one pin pattern for h clock edges (caller is at a negedge).
    // A window that differs from the previous one and lasts at least STABLE+1 edges
    // captures on its edge STABLE+3; callers keep h <= STABLE or h >= STABLE+3.
    task automatic hold(input logic [3:0] sel, input logic [7:0] ssg, input int h);
        bit cap, fd, exp_upd, full;
        int idx, val;
        cap = ({sel, ssg} != {p_sel, p_ssg}) && h >= STABLE + 3 && $countones(sel) == 1;
        p_sel = sel;
        p_ssg = ssg;
        idx = 0;
        for (int i = 0; i < NDIG; i++) if (sel[i]) idx = i;
        val = 15;
        for (int v = 0; v < 10; v++) if (font[v] == ssg[7:1]) val = v;
        sel_in = sel;
        ssg_in = ssg;
        for (int e = 1; e <= h; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp_upd = cap && e == STABLE + 3;
            fd = 1'b0;
            if (exp_upd) begin
                m_dig[idx] = 4'(val); m_dot[idx] = ssg[0]; m_bad[idx] = val == 15; m_mask[idx] = 1'b1;
                full = 1'b1;
                for (int i = 0; i < NDIG; i++) full &= m_mask[i];
                if (full) begin
                    fd = 1'b1;
                    for (int i = 0; i < NDIG; i++) m_mask[i] = 1'b0;
                end
            end
            checks++;
            if (upd !== exp_upd) begin
                failures++; $display("FAIL upd sel=%b ssg=%b edge %0d: got %b want %b", sel, ssg, e, upd, exp_upd);
            end
            if (exp_upd) begin
                checks++;
                if (upd_idx !== 2'(idx)) begin
                    failures++; $display("FAIL upd_idx: got %0d want %0d", upd_idx, idx);
                end
            end
            checks++;
            if (frame_done !== fd) begin
                failures++; $display("FAIL frame_done edge %0d: got %b want %b", e, frame_done, fd);
            end
            checks++;
            if (digits !== m_digits() || dots !== m_vec(0) || bad !== m_vec(1)) begin
                failures++;
                $display("FAIL regs edge %0d: got digits=%h dots=%b bad=%b want digits=%h dots=%b bad=%b",
                         e, digits, dots, bad, m_digits(), m_vec(0), m_vec(1));
            end
            if (upd === 1'b1) upd_seen++;
            if (frame_done === 1'b1) fd_seen++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (digits !== 16'hFFFF || dots !== 4'h0 || bad !== 4'hF || upd !== 1'b0 ||
            upd_idx !== 2'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s: got digits=%h dots=%b bad=%b upd=%b idx=%0d fd=%b want FFFF 0000 1111 0 0 0",
                     tag, digits, dots, bad, upd, upd_idx, frame_done);
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 check_reset_values("reset_async");
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; ssg_in = '0; sel_in = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b0;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_single_capture();
        int u0;
        do_reset();
        u0 = upd_seen;
        hold(4'b0001, 8'b11011010, 20);
        checks++;
        if (digits[3:0] !== 4'd2 || dots[0] !== 1'b0 || bad[0] !== 1'b0 || upd_seen - u0 != 1) begin
            failures++; $display("FAIL single: got d=%h dot=%b bad=%b upds=%0d want 2 0 0 1",
                                 digits[3:0], dots[0], bad[0], upd_seen - u0);
        end
    endtask

    task automatic test_frame();
        int f0;
        do_reset();
        f0 = fd_seen;
        hold(4'b0001, {font[1], 1'b0}, 10);
        hold(4'b0010, {font[2], 1'b0}, 10);
        hold(4'b0100, {font[3], 1'b0}, 10);
        hold(4'b1000, {font[4], 1'b1}, 10);
        checks++;
        if (digits !== 16'h4321 || dots !== 4'b1000 || fd_seen - f0 != 1) begin
            failures++; $display("FAIL frame: got digits=%h dots=%b fd=%0d want 4321 1000 1",
                                 digits, dots, fd_seen - f0);
        end
    endtask

    task automatic test_blank();
        hold(4'b0010, 8'h00, 10);
        checks++;
        if (digits[7:4] !== 4'hF || bad[1] !== 1'b1) begin
            failures++; $display("FAIL blank: got d=%h bad=%b want F 1", digits[7:4], bad[1]);
        end
        hold(4'b0010, 8'b01100000, 10);
        checks++;
        if (digits[7:4] !== 4'd1 || bad[1] !== 1'b0) begin
            failures++; $display("FAIL unblank: got d=%h bad=%b want 1 0", digits[7:4], bad[1]);
        end
    endtask

    task automatic test_bad_select();
        int u0;
        u0 = upd_seen;
        hold(4'b0011, {font[7], 1'b1}, 20);
        hold(4'b0000, {font[8], 1'b0}, 20);
        hold(4'b0100, {font[9], 1'b1}, 3);
        hold(4'b0000, 8'h00, 10);
        checks++;
        if (upd_seen != u0) begin
            failures++; $display("FAIL bad_select: got %0d upd pulses want 0", upd_seen - u0);
        end
    endtask

    task automatic test_recapture();
        int f0;
        do_reset();
        f0 = fd_seen;
        hold(4'b0001, {font[5], 1'b0}, 10);
        hold(4'b0001, {font[6], 1'b0}, 10);
        checks++;
        if (digits[3:0] !== 4'd6 || fd_seen != f0) begin
            failures++; $display("FAIL recapture: got d=%h fd=%0d want 6 0", digits[3:0], fd_seen - f0);
        end
        hold(4'b0010, {font[1], 1'b0}, 10);
        hold(4'b0100, {font[2], 1'b0}, 10);
        hold(4'b1000, {font[3], 1'b0}, 10);
        checks++;
        if (fd_seen - f0 != 1) begin
            failures++; $display("FAIL recapture_frame: got %0d frame pulses want 1", fd_seen - f0);
        end
    endtask

    task automatic test_reset_mid();
        hold(4'b0001, {font[5], 1'b1}, 10);
        hold(4'b0010, {font[7], 1'b0}, 3);
        #2 rst = 1'b1;
        #1 check_reset_values("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        hold(4'b0010, {font[7], 1'b0}, 10);
    endtask

    task automatic test_random();
        logic [3:0] sel;
        logic [7:0] ssg;
        int h;
        for (int n = 0; n < 60; n++) begin
            do begin
                sel = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
                ssg = $urandom_range(0, 4) == 0 ? 8'($urandom) : {font[$urandom_range(0, 9)], 1'($urandom)};
            end while ({sel, ssg} == {p_sel, p_ssg});
            h = $urandom_range(0, 2) == 0 ? $urandom_range(1, STABLE) : $urandom_range(STABLE + 3, STABLE + 8);
            hold(sel, ssg, h);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_frame();
        test_blank();
        test_bad_select();
        test_recapture();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
